// File: rtl/regfile_sb.sv
// Register file with per-register scoreboard (busy + producer tag) and NRD combinational read ports.
// Optional same-cycle writeback-to-read bypass is enabled by defining REGFILE_BYPASS_EN.
module regfile_sb #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NRD    = 2,
  parameter int TAG_W  = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   we,
  input  logic [ADDR_W-1:0]      waddr,
  input  logic [DATA_W-1:0]      wdata,
  input  logic [TAG_W-1:0]       wtag,
  input  logic                   rsv_en,
  input  logic [ADDR_W-1:0]      rsv_addr,
  input  logic [TAG_W-1:0]       rsv_tag,
  input  logic                   flush,
  input  logic [NRD-1:0]         re,
  input  logic [NRD*ADDR_W-1:0]  raddr,
  output logic [NRD*DATA_W-1:0]  rdata,
  output logic [NRD-1:0]         rbusy,
  output logic [NRD*TAG_W-1:0]   rtag
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DATA_W-1:0] data_d [DEPTH];
  logic              busy_q [DEPTH];
  logic              busy_d [DEPTH];
  logic [TAG_W-1:0]  tag_q  [DEPTH];
  logic [TAG_W-1:0]  tag_d  [DEPTH];

  // Priority, lowest to highest: matching writeback clears busy, reservation sets it, flush clears all.
  always_comb begin
    data_d = data_q;
    busy_d = busy_q;
    tag_d  = tag_q;
    if (we && (waddr != '0)) begin
      data_d[waddr] = wdata;
      if (busy_q[waddr] && (tag_q[waddr] == wtag)) begin
        busy_d[waddr] = 1'b0;
      end
    end
    if (rsv_en && !flush && (rsv_addr != '0)) begin
      busy_d[rsv_addr] = 1'b1;
      tag_d[rsv_addr]  = rsv_tag;
    end
    if (flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        busy_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
        busy_q[i] <= 1'b0;
        tag_q[i]  <= '0;
      end
    end else begin
      data_q <= data_d;
      busy_q <= busy_d;
      tag_q  <= tag_d;
    end
  end

  // Register 0 and disabled ports read as all-zero; everything reads zero while reset is held.
  always_comb begin
    rdata = '0;
    rbusy = '0;
    rtag  = '0;
    for (int k = 0; k < NRD; k++) begin
      if (rst && re[k] && (raddr[k*ADDR_W +: ADDR_W] != '0)) begin
`ifdef REGFILE_BYPASS_EN
        if (we && (raddr[k*ADDR_W +: ADDR_W] == waddr)) begin
          rdata[k*DATA_W +: DATA_W] = wdata;
          rbusy[k]                  = busy_d[raddr[k*ADDR_W +: ADDR_W]];
          rtag[k*TAG_W +: TAG_W]    = tag_d[raddr[k*ADDR_W +: ADDR_W]];
        end else begin
          rdata[k*DATA_W +: DATA_W] = data_q[raddr[k*ADDR_W +: ADDR_W]];
          rbusy[k]                  = busy_q[raddr[k*ADDR_W +: ADDR_W]];
          rtag[k*TAG_W +: TAG_W]    = tag_q[raddr[k*ADDR_W +: ADDR_W]];
        end
`else
        rdata[k*DATA_W +: DATA_W] = data_q[raddr[k*ADDR_W +: ADDR_W]];
        rbusy[k]                  = busy_q[raddr[k*ADDR_W +: ADDR_W]];
        rtag[k*TAG_W +: TAG_W]    = tag_q[raddr[k*ADDR_W +: ADDR_W]];
`endif
      end
    end
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: reset sweep, table of scoreboard scenarios, async reset sequence.
// Expected values track REGFILE_BYPASS_EN when the bench is built with the same define.
module tb_regfile_sb;

`ifdef REGFILE_BYPASS_EN
  localparam bit BP = 1'b1;
`else
  localparam bit BP = 1'b0;
`endif

  localparam int EXP_W = 72;

  logic        clk;
  logic        rst;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [2:0]  wtag;
  logic        rsv_en;
  logic [4:0]  rsv_addr;
  logic [2:0]  rsv_tag;
  logic        flush;
  logic [1:0]  re;
  logic [9:0]  raddr;
  logic [63:0] rdata;
  logic [1:0]  rbusy;
  logic [5:0]  rtag;

  typedef struct {
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [2:0]  wtag;
    logic        rsv_en;
    logic [4:0]  rsv_addr;
    logic [2:0]  rsv_tag;
    logic        flush;
    logic [1:0]  re;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [31:0] ed0;
    logic        eb0;
    logic [2:0]  et0;
    logic [31:0] ed1;
    logic        eb1;
    logic [2:0]  et1;
  } vec_t;

  logic [EXP_W-1:0] exp_q[$];
  vec_t vt [16];
  int n_vec;
  int n_miss;

  regfile_sb dut (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata), .wtag(wtag),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .rsv_tag(rsv_tag), .flush(flush),
    .re(re), .raddr(raddr), .rdata(rdata), .rbusy(rbusy), .rtag(rtag)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(
    input logic w, input logic [4:0] wa, input logic [31:0] wd, input logic [2:0] wt,
    input logic rv, input logic [4:0] rva, input logic [2:0] rvt, input logic fl,
    input logic [1:0] r, input logic [4:0] a0, input logic [4:0] a1,
    input logic [31:0] d0, input logic b0, input logic [2:0] t0,
    input logic [31:0] d1, input logic b1, input logic [2:0] t1);
    vec_t v;
    v.we = w; v.waddr = wa; v.wdata = wd; v.wtag = wt;
    v.rsv_en = rv; v.rsv_addr = rva; v.rsv_tag = rvt; v.flush = fl;
    v.re = r; v.ra0 = a0; v.ra1 = a1;
    v.ed0 = d0; v.eb0 = b0; v.et0 = t0; v.ed1 = d1; v.eb1 = b1; v.et1 = t1;
    return v;
  endfunction

  function automatic logic [EXP_W-1:0] pack(
    input logic [31:0] d0, input logic b0, input logic [2:0] t0,
    input logic [31:0] d1, input logic b1, input logic [2:0] t1);
    return {d1, d0, b1, b0, t1, t0};
  endfunction

  // driver tasks
  task automatic drive_idle();
    we = 1'b0; waddr = '0; wdata = '0; wtag = '0;
    rsv_en = 1'b0; rsv_addr = '0; rsv_tag = '0; flush = 1'b0;
    re = 2'b00; raddr = '0;
  endtask

  task automatic drive_vec(input vec_t v);
    we = v.we; waddr = v.waddr; wdata = v.wdata; wtag = v.wtag;
    rsv_en = v.rsv_en; rsv_addr = v.rsv_addr; rsv_tag = v.rsv_tag; flush = v.flush;
    re = v.re; raddr = {v.ra1, v.ra0};
  endtask

  // scoreboard: pop expected, compare against the current read outputs
  task automatic check(input string name);
    logic [EXP_W-1:0] act;
    logic [EXP_W-1:0] exp;
    act = {rdata, rbusy, rtag};
    n_vec++;
    if (exp_q.size() == 0) begin
      n_miss++;
      $display("FAIL %s: scoreboard empty, got %h", name, act);
    end else begin
      exp = exp_q.pop_front();
      if (act !== exp) begin
        n_miss++;
        $display("FAIL %s: got rdata=%h rbusy=%b rtag=%h, expected rdata=%h rbusy=%b rtag=%h",
                 name, act[71:8], act[7:6], act[5:0], exp[71:8], exp[7:6], exp[5:0]);
      end
    end
  endtask

  initial begin
    n_vec = 0;
    n_miss = 0;

    //             we wa  wdata         wt rv rva rvt fl re     a0 a1  d0/b0/t0                                   d1/b1/t1
    vt[0]  = mk(0, 0, 0,            0, 1, 5, 3, 0, 2'b11, 5, 7,  0, 0, 0,                                       0, 0, 0);
    vt[1]  = mk(1, 5, 32'hDEADBEEF, 3, 0, 0, 0, 0, 2'b11, 5, 5,  BP ? 32'hDEADBEEF : 32'h0, !BP, 3,         BP ? 32'hDEADBEEF : 32'h0, !BP, 3);
    vt[2]  = mk(0, 0, 0,            0, 1, 7, 1, 0, 2'b11, 5, 7,  32'hDEADBEEF, 0, 3,                           0, 0, 0);
    vt[3]  = mk(0, 0, 0,            0, 1, 7, 2, 0, 2'b11, 7, 0,  0, 1, 1,                                       0, 0, 0);
    vt[4]  = mk(1, 7, 32'h11111111, 1, 0, 0, 0, 0, 2'b01, 7, 5,  BP ? 32'h11111111 : 32'h0, 1, 2,             0, 0, 0);
    vt[5]  = mk(1, 7, 32'h22222222, 2, 0, 0, 0, 0, 2'b11, 7, 7,  BP ? 32'h22222222 : 32'h11111111, !BP, 2,   BP ? 32'h22222222 : 32'h11111111, !BP, 2);
    vt[6]  = mk(0, 0, 0,            0, 0, 0, 0, 0, 2'b11, 7, 5,  32'h22222222, 0, 2,                           32'hDEADBEEF, 0, 3);
    vt[7]  = mk(1, 9, 32'hA5A5A5A5, 4, 1, 9, 6, 0, 2'b11, 9, 9,  BP ? 32'hA5A5A5A5 : 32'h0, BP, BP ? 3'd6 : 3'd0, BP ? 32'hA5A5A5A5 : 32'h0, BP, BP ? 3'd6 : 3'd0);
    vt[8]  = mk(0, 0, 0,            0, 0, 0, 0, 0, 2'b11, 9, 9,  32'hA5A5A5A5, 1, 6,                           32'hA5A5A5A5, 1, 6);
    vt[9]  = mk(0, 0, 0,            0, 1, 3, 1, 0, 2'b11, 3, 9,  0, 0, 0,                                       32'hA5A5A5A5, 1, 6);
    vt[10] = mk(0, 0, 0,            0, 1, 4, 2, 0, 2'b11, 3, 4,  0, 1, 1,                                       0, 0, 0);
    vt[11] = mk(1, 4, 32'h00000044, 7, 1, 6, 5, 1, 2'b11, 4, 6,  BP ? 32'h44 : 32'h0, !BP, 2,                  0, 0, 0);
    vt[12] = mk(0, 0, 0,            0, 0, 0, 0, 0, 2'b11, 3, 4,  0, 0, 1,                                       32'h44, 0, 2);
    vt[13] = mk(0, 0, 0,            0, 0, 0, 0, 0, 2'b11, 6, 9,  0, 0, 0,                                       32'hA5A5A5A5, 0, 6);
    vt[14] = mk(1, 0, 32'hFFFFFFFF, 1, 1, 0, 7, 0, 2'b11, 0, 0,  0, 0, 0,                                       0, 0, 0);
    vt[15] = mk(0, 0, 0,            0, 0, 0, 0, 0, 2'b11, 0, 5,  0, 0, 0,                                       32'hDEADBEEF, 0, 3);

    // reset held: outputs zero and writes/reserves ignored
    rst = 1'b0;
    drive_idle();
    we = 1'b1; waddr = 5'd1; wdata = 32'h12345678; rsv_en = 1'b1; rsv_addr = 5'd1; rsv_tag = 3'd4;
    re = 2'b11; raddr = {5'd1, 5'd1};
    repeat (2) @(negedge clk);
    exp_q.push_back('0);
    #1 check("in_reset");
    @(negedge clk);
    drive_idle();
    rst = 1'b1;

    // every register reads zero on both ports after reset
    for (int a = 1; a < 32; a++) begin
      @(negedge clk);
      re = 2'b11;
      raddr = {5'(a), 5'(a)};
      exp_q.push_back('0);
      #1 check($sformatf("post_reset_x%0d", a));
    end

    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      drive_vec(vt[i]);
      exp_q.push_back(pack(vt[i].ed0, vt[i].eb0, vt[i].et0, vt[i].ed1, vt[i].eb1, vt[i].et1));
      #1 check($sformatf("vec%0d", i));
    end

    // random idle re-reads of x5: stored value must be stable
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive_idle();
      re = 2'($urandom_range(1, 3));
      raddr = {5'd5, 5'd5};
      exp_q.push_back(pack(re[0] ? 32'hDEADBEEF : 32'h0, 1'b0, re[0] ? 3'd3 : 3'd0,
                           re[1] ? 32'hDEADBEEF : 32'h0, 1'b0, re[1] ? 3'd3 : 3'd0));
      #1 check($sformatf("x5_stable%0d", i));
    end

    // asynchronous reset mid-cycle with x2 pending
    @(negedge clk);
    drive_idle();
    rsv_en = 1'b1; rsv_addr = 5'd2; rsv_tag = 3'd5;
    @(negedge clk);
    drive_idle();
    re = 2'b11; raddr = {5'd5, 5'd2};
    exp_q.push_back(pack(32'h0, 1'b1, 3'd5, 32'hDEADBEEF, 1'b0, 3'd3));
    #1 check("x2_busy");
    @(posedge clk);
    #3;
    rst = 1'b0;
    we = 1'b1; waddr = 5'd2; wdata = 32'hCAFEF00D; wtag = 3'd1;
    rsv_en = 1'b1; rsv_addr = 5'd8; rsv_tag = 3'd7;
    exp_q.push_back('0);
    #1 check("async_reset");
    @(negedge clk);
    drive_idle();
    rst = 1'b1;
    re = 2'b11; raddr = {5'd8, 5'd2};
    exp_q.push_back('0);
    #1 check("after_release");
    @(negedge clk);
    exp_q.push_back('0);
    #1 check("after_release_edge");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
